// File: rtl/vram_text_writer.sv
// vram_text_writer: host text commands (PUT/SET/NEWLINE/CLEAR) to registered VRAM write strobes with a text cursor.
// Optional power-up clear with C_FILL when VRAM_TEXT_WRITER_AUTO_CLR_EN is defined.
module vram_text_writer #(
  parameter int C_DAT_W = 8,
  parameter int C_ADR_W = 11,
  parameter int C_COLS = 80,
  parameter int C_ROWS = 25,
  parameter int C_COL_W = 7,
  parameter int C_ROW_W = 5,
  parameter logic [C_DAT_W-1:0] C_FILL = 8'h20
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic               CMD_VLD_i,
  output logic               CMD_RDY_o,
  input  logic [1:0]         CMD_i,
  input  logic [C_DAT_W-1:0] DAT_i,
  input  logic [C_COL_W-1:0] POS_COL_i,
  input  logic [C_ROW_W-1:0] POS_ROW_i,
  output logic               WE_o,
  output logic [C_ADR_W-1:0] WA_o,
  output logic [C_DAT_W-1:0] WD_o,
  output logic [C_COL_W-1:0] CUR_COL_o,
  output logic [C_ROW_W-1:0] CUR_ROW_o,
  output logic               BUSY_o
);
`ifdef VRAM_TEXT_WRITER_AUTO_CLR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam logic [C_COL_W-1:0] COL_MAX = C_COL_W'(C_COLS - 1);
  localparam logic [C_ROW_W-1:0] ROW_MAX = C_ROW_W'(C_ROWS - 1);
  localparam logic [C_ADR_W-1:0] COLS_A = C_ADR_W'(C_COLS);
  localparam logic [C_ADR_W:0] LAST = (C_ADR_W + 1)'(C_COLS * C_ROWS);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [C_ADR_W-1:0] row_base;
  logic [C_ADR_W:0] fill_adr;
  logic [C_DAT_W-1:0] fill_chr;
  logic accept, row_end;
  logic [C_ROW_W-1:0] nxt_row, set_row;
  logic [C_COL_W-1:0] set_col;
  logic [C_ADR_W-1:0] nxt_base, set_base, put_adr;
  always_comb begin
    accept = CMD_VLD_i & CMD_RDY_o;
    row_end = CUR_ROW_o == ROW_MAX;
    nxt_row = row_end ? '0 : CUR_ROW_o + 1'b1;
    nxt_base = row_end ? '0 : row_base + COLS_A;
    set_col = POS_COL_i > COL_MAX ? COL_MAX : POS_COL_i;
    set_row = POS_ROW_i > ROW_MAX ? ROW_MAX : POS_ROW_i;
    set_base = C_ADR_W'(set_row) * COLS_A;
    put_adr = row_base + C_ADR_W'(CUR_COL_o);
  end
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state <= AUTO ? FILL : IDLE;
      CMD_RDY_o <= !AUTO;
      BUSY_o <= AUTO;
      WE_o <= 1'b0;
      WA_o <= '0;
      WD_o <= '0;
      CUR_COL_o <= '0;
      CUR_ROW_o <= '0;
      row_base <= '0;
      fill_adr <= '0;
      fill_chr <= AUTO ? C_FILL : '0;
    end else begin
      WE_o <= 1'b0;
      if (state == FILL) begin
        if (fill_adr == LAST) begin
          state <= IDLE;
          CMD_RDY_o <= 1'b1;
          BUSY_o <= 1'b0;
          CUR_COL_o <= '0;
          CUR_ROW_o <= '0;
          row_base <= '0;
        end else begin
          WE_o <= 1'b1;
          WA_o <= fill_adr[C_ADR_W-1:0];
          WD_o <= fill_chr;
          fill_adr <= fill_adr + 1'b1;
        end
      end else if (accept) begin
        case (CMD_i)
          2'd0: begin
            WE_o <= 1'b1;
            WA_o <= put_adr;
            WD_o <= DAT_i;
            CUR_COL_o <= CUR_COL_o == COL_MAX ? '0 : CUR_COL_o + 1'b1;
            CUR_ROW_o <= CUR_COL_o == COL_MAX ? nxt_row : CUR_ROW_o;
            row_base <= CUR_COL_o == COL_MAX ? nxt_base : row_base;
          end
          2'd1: begin
            CUR_COL_o <= set_col;
            CUR_ROW_o <= set_row;
            row_base <= set_base;
          end
          2'd2: begin
            CUR_COL_o <= '0;
            CUR_ROW_o <= nxt_row;
            row_base <= nxt_base;
          end
          default: begin
            // Cell 0 is written on the accept edge, the rest stream from fill_adr=1.
            state <= FILL;
            CMD_RDY_o <= 1'b0;
            BUSY_o <= 1'b1;
            WE_o <= 1'b1;
            WA_o <= '0;
            WD_o <= DAT_i;
            fill_chr <= DAT_i;
            fill_adr <= (C_ADR_W + 1)'(1);
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vram_text_writer.sv
// tb_vram_text_writer: directed vector table plus fill/reset sequences for vram_text_writer.
module tb_vram_text_writer;
  logic clk = 1'b0, xarst = 1'b0, vld = 1'b0;
  logic [1:0] cmd = '0;
  logic [7:0] dat = '0;
  logic [6:0] pcol = '0;
  logic [4:0] prow = '0;
  logic rdy, we, busy;
  logic [10:0] wa;
  logic [7:0] wd;
  logic [6:0] col;
  logic [4:0] row;
  int n_chk = 0, n_fail = 0;
  vram_text_writer dut (
    .CK_i(clk), .XARST_i(xarst), .CMD_VLD_i(vld), .CMD_RDY_o(rdy), .CMD_i(cmd),
    .DAT_i(dat), .POS_COL_i(pcol), .POS_ROW_i(prow), .WE_o(we), .WA_o(wa),
    .WD_o(wd), .CUR_COL_o(col), .CUR_ROW_o(row), .BUSY_o(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] cmd; logic [7:0] dat; logic [6:0] pc; logic [4:0] pr;
    logic we; int wa; logic [7:0] wd; int col; int row;
  } vec_t;
  vec_t v[17];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_fill(input logic [7:0] fc, input int stop_at, input int c0, input int r0, input string tag);
    int np = 0, bc = 0, bad = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      if (we) begin
        if (wa !== np[10:0] || wd !== fc) bad++;
        np++;
      end
      if (rdy !== 1'b0 || col !== c0[6:0] || row !== r0[4:0]) bad++;
      if (stop_at > 0 && np == stop_at) break;
    end
    chk({tag, " addr/data/rdy/cursor errors"}, bad, 0);
    if (stop_at == 0) begin
      chk({tag, " write pulses"}, np, 2000);
      chk({tag, " busy cycles >= 2000"}, int'(bc >= 2000), 1);
      chk({tag, " busy ended"}, busy, 0);
    end else chk({tag, " pulses before abort"}, np, stop_at);
  endtask
  initial begin
    v[0]  = '{2'd0, 8'h41, 7'd0,   5'd0,  1'b1, 0,    8'h41, 1,  0};
    v[1]  = '{2'd1, 8'h00, 7'd79,  5'd24, 1'b0, 0,    8'h00, 79, 24};
    v[2]  = '{2'd0, 8'h5A, 7'd0,   5'd0,  1'b1, 1999, 8'h5A, 0,  0};
    v[3]  = '{2'd1, 8'h00, 7'd90,  5'd30, 1'b0, 0,    8'h00, 79, 24};
    v[4]  = '{2'd1, 8'h00, 7'd3,   5'd2,  1'b0, 0,    8'h00, 3,  2};
    v[5]  = '{2'd2, 8'h00, 7'd0,   5'd0,  1'b0, 0,    8'h00, 0,  3};
    v[6]  = '{2'd0, 8'h42, 7'd0,   5'd0,  1'b1, 240,  8'h42, 1,  3};
    v[7]  = '{2'd1, 8'h00, 7'd127, 5'd5,  1'b0, 0,    8'h00, 79, 5};
    v[8]  = '{2'd2, 8'h00, 7'd0,   5'd0,  1'b0, 0,    8'h00, 0,  6};
    v[9]  = '{2'd1, 8'h00, 7'd5,   5'd24, 1'b0, 0,    8'h00, 5,  24};
    v[10] = '{2'd2, 8'h00, 7'd0,   5'd0,  1'b0, 0,    8'h00, 0,  0};
    v[11] = '{2'd1, 8'h00, 7'd78,  5'd0,  1'b0, 0,    8'h00, 78, 0};
    v[12] = '{2'd0, 8'h61, 7'd0,   5'd0,  1'b1, 78,   8'h61, 79, 0};
    v[13] = '{2'd0, 8'h62, 7'd0,   5'd0,  1'b1, 79,   8'h62, 0,  1};
    v[14] = '{2'd0, 8'h63, 7'd0,   5'd0,  1'b1, 80,   8'h63, 1,  1};
    v[15] = '{2'd0, 8'h64, 7'd0,   5'd0,  1'b1, 81,   8'h64, 2,  1};
    v[16] = '{2'd0, 8'h65, 7'd0,   5'd0,  1'b1, 82,   8'h65, 3,  1};
    repeat (3) @(negedge clk);
    chk("reset we", we, 0);
    chk("reset wa", wa, 0);
    chk("reset wd", wd, 0);
    chk("reset col", col, 0);
    chk("reset row", row, 0);
    chk("reset busy", busy, 0);
    xarst = 1'b1;
`ifdef VRAM_TEXT_WRITER_AUTO_CLR_EN
    run_fill(8'h20, 0, 0, 0, "auto clear");
`endif
    chk("idle rdy", rdy, 1);
    chk("idle busy", busy, 0);
    foreach (v[i]) begin
      cmd = v[i].cmd; dat = v[i].dat; pcol = v[i].pc; prow = v[i].pr; vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d we", i), we, v[i].we);
      if (v[i].we) begin
        chk($sformatf("vec%0d wa", i), wa, v[i].wa);
        chk($sformatf("vec%0d wd", i), wd, v[i].wd);
      end
      chk($sformatf("vec%0d col", i), col, v[i].col);
      chk($sformatf("vec%0d row", i), row, v[i].row);
      chk($sformatf("vec%0d rdy", i), rdy, 1);
    end
    vld = 1'b0;
    @(negedge clk);
    chk("no-cmd we", we, 0);
    cmd = 2'd3; dat = 8'h2E; vld = 1'b1;
    @(posedge clk);
    #1 cmd = 2'd0; dat = 8'h77;
    run_fill(8'h2E, 0, 3, 1, "clear");
    chk("post clear rdy", rdy, 1);
    chk("post clear we", we, 0);
    chk("post clear col", col, 0);
    chk("post clear row", row, 0);
    @(posedge clk);
    #1 vld = 1'b0;
    @(negedge clk);
    chk("held put we", we, 1);
    chk("held put wa", wa, 0);
    chk("held put wd", wd, 8'h77);
    chk("held put col", col, 1);
    cmd = 2'd3; dat = 8'h11; vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    run_fill(8'h11, 500, 1, 0, "clear2");
    #2 xarst = 1'b0;
    #1;
    chk("abort we", we, 0);
    chk("abort busy", busy, 0);
    chk("abort wa", wa, 0);
    chk("abort col", col, 0);
    @(negedge clk);
    xarst = 1'b1;
`ifdef VRAM_TEXT_WRITER_AUTO_CLR_EN
    run_fill(8'h20, 0, 0, 0, "refill");
`endif
    chk("after abort rdy", rdy, 1);
    cmd = 2'd0; dat = 8'h33; vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    @(negedge clk);
    chk("after abort put wa", wa, 0);
    chk("after abort put we", we, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
